// File: rtl/scroll_pixel_pipe.sv
// scroll_pixel_pipe: two-stage pixel compositor with frame-synchronous shadows, camera scroll and collision mask
module scroll_pixel_pipe #(
  parameter int PIXEL_WIDTH     = 12,
  parameter int SCREEN_WIDTH    = 10,
  parameter int PHY_WIDTH       = 14,
  parameter int OBSTACLE_NUM    = 16,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int OBSTACLE_UNIT   = 10,
  parameter int CHAR_WIDTH_X    = 40,
  parameter int CHAR_WIDTH_Y    = 40,
  parameter int MAP_X_OFFSET    = 120,
  parameter int MAP_WIDTH_X     = 480,
  parameter int BLOCK_HEIGHT    = 480,
  parameter int SCROLL_STEP     = 8,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT  = 12'hF0F,
  parameter logic [PIXEL_WIDTH-1:0] OBSTACLE_RGB = 12'h000,
  parameter logic [PIXEL_WIDTH-1:0] BORDER_RGB   = 12'h5FF
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst_n,
  input  logic                                    video_on,
  input  logic [SCREEN_WIDTH-1:0]                 x,
  input  logic [SCREEN_WIDTH-1:0]                 y,
  input  logic                                    frame_start,
  input  logic [4:0]                              camera_y,
  input  logic [PHY_WIDTH-1:0]                    char_abs_x,
  input  logic [PHY_WIDTH-1:0]                    char_abs_y,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_x,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_y,
  input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obstacle_block_width,
  output logic [PHY_WIDTH-1:0]                    map_x,
  output logic [PHY_WIDTH-1:0]                    map_y,
  output logic [SCREEN_WIDTH-1:0]                 char_x_rom,
  output logic [SCREEN_WIDTH-1:0]                 char_y_rom,
  input  logic [PIXEL_WIDTH-1:0]                  map_rgb,
  input  logic [PIXEL_WIDTH-1:0]                  char_rgb,
  output logic [PIXEL_WIDTH-1:0]                  rgb,
  output logic [PHY_WIDTH-1:0]                    cam_offset,
  output logic [OBSTACLE_NUM-1:0]                 hit_mask
);
  localparam int W = PHY_WIDTH + 2;
  localparam logic [PHY_WIDTH-1:0] STEP = PHY_WIDTH'(SCROLL_STEP);
  typedef enum logic [1:0] {HOLD, SCROLL_UP, SCROLL_DOWN} cam_e;
  cam_e dir;
  logic [PHY_WIDTH-1:0] target, cam_q, cam_d, diff_up, diff_dn;
  logic [PHY_WIDTH-1:0] cx_q, cy_q;
  logic cvld_q;
  logic [OBSTACLE_NUM*PHY_WIDTH-1:0] ox_q, oy_q;
  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] ow_q;
  logic [W-1:0] xw, wy;
  logic char_hit, map_hit, opaque;
  logic [OBSTACLE_NUM-1:0] obs_hit, ohit_q, acc_q, acc_d;
  logic vid_q, chit_q, mhit_q;
  logic [PIXEL_WIDTH-1:0] rgb_d;
  assign target = PHY_WIDTH'(camera_y * BLOCK_HEIGHT);
  assign cam_offset = cam_q;
  always_comb begin
    diff_up = target - cam_q;
    diff_dn = cam_q - target;
    dir = target > cam_q ? SCROLL_UP : target < cam_q ? SCROLL_DOWN : HOLD;
    cam_d = SCROLL_STEP == 0 ? target :
            dir == SCROLL_UP ? cam_q + (diff_up < STEP ? diff_up : STEP) :
            dir == SCROLL_DOWN ? cam_q - (diff_dn < STEP ? diff_dn : STEP) : cam_q;
  end
  // All comparisons are done two bits wider than positions so nothing wraps near the top of the range
  assign xw = W'(x);
  assign wy = W'(y) + W'(cam_q);
  assign char_hit = cvld_q && xw >= W'(cx_q) && xw < W'(cx_q) + W'(CHAR_WIDTH_X) &&
                    wy >= W'(cy_q) && wy < W'(cy_q) + W'(CHAR_WIDTH_Y);
  assign map_hit = xw >= W'(MAP_X_OFFSET) && xw < W'(MAP_X_OFFSET + MAP_WIDTH_X);
  genvar i;
  for (i = 0; i < OBSTACLE_NUM; i++) begin : g_obs
    logic [BLOCK_LEN_WIDTH-1:0] len;
    logic [PHY_WIDTH-1:0] px, py;
    assign len = ow_q[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
    assign px = ox_q[i*PHY_WIDTH +: PHY_WIDTH];
    assign py = oy_q[i*PHY_WIDTH +: PHY_WIDTH];
    assign obs_hit[i] = len != '0 && xw >= W'(px) && xw < W'(px) + W'(len) * W'(OBSTACLE_UNIT) &&
                        wy >= W'(py) && wy < W'(py) + W'(OBSTACLE_UNIT);
  end
  always_comb begin
    opaque = chit_q && char_rgb != TRANSPARENT;
    rgb_d = !vid_q ? '0 : opaque ? char_rgb : |ohit_q ? OBSTACLE_RGB : mhit_q ? map_rgb : BORDER_RGB;
    acc_d = frame_start ? '0 : acc_q | ((vid_q && opaque) ? ohit_q : '0);
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cam_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      cvld_q <= 1'b0;
      ox_q <= '0;
      oy_q <= '0;
      ow_q <= '0;
      hit_mask <= '0;
      acc_q <= '0;
      vid_q <= 1'b0;
      chit_q <= 1'b0;
      mhit_q <= 1'b0;
      ohit_q <= '0;
      char_x_rom <= '0;
      char_y_rom <= '0;
      map_x <= '0;
      map_y <= '0;
      rgb <= '0;
    end else begin
      if (frame_start) begin
        cam_q <= cam_d;
        cx_q <= char_abs_x;
        cy_q <= char_abs_y;
        cvld_q <= 1'b1;
        ox_q <= obstacle_abs_pos_x;
        oy_q <= obstacle_abs_pos_y;
        ow_q <= obstacle_block_width;
        hit_mask <= acc_q;
      end
      acc_q <= acc_d;
      vid_q <= video_on;
      chit_q <= char_hit;
      mhit_q <= map_hit;
      ohit_q <= obs_hit;
      char_x_rom <= SCREEN_WIDTH'(xw - W'(cx_q));
      char_y_rom <= SCREEN_WIDTH'(wy - W'(cy_q));
      map_x <= PHY_WIDTH'(xw - W'(MAP_X_OFFSET));
      map_y <= PHY_WIDTH'(wy);
      rgb <= rgb_d;
    end
  end
endmodule
